pipe_stage_buf: RTL
===================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 SHALL have parameter NOP_VALUE, default 32'h00000013 (addi x0,x0,0), giving the payload presented while the stage holds no valid data.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, giving the stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  discard all held entries (successor of the old CLR behaviour).
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept a payload this cycle.
REQ-009 in_data  input  DATA_WIDTH  upstream payload.
REQ-010 out_valid  output  1  stage presents a valid payload.
REQ-011 out_ready  input  1  downstream accepts; deassertion is the stall (successor of the old EN behaviour).
REQ-012 out_data  output  DATA_WIDTH  payload to downstream.
REQ-013 stall_cnt  output  CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Input transfer ("in fire") SHALL occur when in_valid=1, in_ready=1 and flush=0.
REQ-015 Output transfer ("out fire") SHALL occur when out_valid=1 and out_ready=1.
REQ-016 Storage SHALL be a main register and one skid register; FSM states are EMPTY, BUSY (main valid) and FULL (main and skid valid).
REQ-017 in_ready SHALL be a registered signal, 1 in EMPTY and BUSY, 0 in FULL, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in BUSY and FULL; out_data SHALL be the main register when out_valid=1, else NOP_VALUE.
REQ-019 EMPTY: in fire -> BUSY, main <= in_data; otherwise stay EMPTY.
REQ-020 BUSY: in fire with out fire -> BUSY, main <= in_data; in fire without out fire -> FULL, skid <= in_data; out fire only -> EMPTY; neither -> BUSY, main held.
REQ-021 FULL: out fire -> BUSY, main <= skid; otherwise stay FULL with both registers held.
REQ-022 Latency SHALL be one cycle from in fire into EMPTY to out_valid=1 with that payload.
REQ-023 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush or reset.
REQ-024 Full throughput SHALL be sustained: one transfer per cycle when in_valid=1 and out_ready=1 continuously.
REQ-025 flush=1 SHALL force the next state to EMPTY and drive in_ready=1 on the next cycle. The same-cycle input is discarded; a same-cycle out fire still counts as delivered.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with out_valid=1, out_ready=0 and flush=0, saturating at all-ones with no wrap.
REQ-027 Registers not valid SHALL not be required to hold any particular value internally; only out_data (NOP_VALUE) is observable.

Reset
REQ-028 On a clk edge with rst_n=0 the block SHALL enter EMPTY: out_valid=0, out_data=NOP_VALUE, in_ready=1 on the following cycle, stall_cnt=0.
REQ-029 Reset SHALL take priority over flush and any transfer, including in FULL.

Structure
REQ-030 The shared pipeline package SHALL hold the state enum (EMPTY, BUSY, FULL) and the RV32I NOP constant used as the NOP_VALUE default.
REQ-031 The block SHALL be a single module with no sub-modules; the stall counter stays inline.

Verification
REQ-032 Reset then idle -> out_valid=0, out_data=32'h00000013, in_ready=1, stall_cnt=0.
REQ-033 Stream 0xA0..0xA7 with out_ready=1 -> out_data 0xA0..0xA7 on consecutive cycles, each one cycle after its input, in_ready constantly 1.
REQ-034 Send 0xB0, 0xB1 with out_ready=0 -> FULL, in_ready=0, out_data=0xB0, stall_cnt rises by 1 per cycle. Raise out_ready -> 0xB0 then 0xB1 delivered, in_ready=1 again.
REQ-035 In FULL (0xC0, 0xC1) assert flush with in_valid=1, in_data=0xC2 -> next cycle out_valid=0, out_data=NOP, in_ready=1; 0xC2 never appears.
REQ-036 With CNT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-037 rst_n=0 in FULL with flush=1 and in_valid=1 -> reset state per REQ-028; stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: the buffer state encoding and the RV32I NOP.
// The NOP is the payload a stage presents while it holds nothing valid.
package pipe_stage_buf_pkg;

    // EMPTY: nothing held; BUSY: main valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV32I_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) pipeline stage buffer with valid/ready handshakes
// on both sides and a registered in_ready, so there is no combinational path
// from out_ready back to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      drop every held entry and the same-cycle input
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle (registered)
//   in_data    upstream payload
//   out_valid  stage presents a valid payload
//   out_ready  downstream accepts; low means stall
//   out_data   main register when valid, NOP_VALUE otherwise
//   stall_cnt  saturating count of cycles with out_valid=1, out_ready=0
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]     NOP_VALUE  = DATA_WIDTH'(RV32I_NOP),
    parameter int unsigned               CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    state_t                state_q;
    state_t                state_d;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [CNT_WIDTH-1:0]  stall_q;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic stall_inc;

    assign in_fire  = in_valid && in_ready_q && !flush;
    assign out_fire = out_valid && out_ready;

    // State, in_ready and stall counter; reset wins over flush and transfers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            // in_ready is the registered decode of the next state
            in_ready_q <= (state_d != ST_FULL);
            if (stall_inc) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    // Payload registers carry no reset; their content only matters when valid
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_q <= in_data;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_data;
        end
    end

    // Next-state and register-load decode
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d      = ST_BUSY;
                    load_main_in = 1'b1;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no input can arrive
                if (out_fire) begin
                    state_d        = ST_BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_data  = out_valid ? main_q : NOP_VALUE;
        stall_inc = out_valid && !out_ready && !flush && (stall_q != '1);
    end

    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_q;

endmodule
